hawk_rd_arb: RTL

HAWK_RD_ARB -- requirements
Module: hawk_rd_arb

---
 rtl/hawk_rd_arb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hawk_rd_arb.sv
// Round-robin arbiter sharing one AXI read master among NUM_REQ requesters, one burst at a time.
// AR is issued one cycle after the grant; R beats are routed combinationally to the owner, whose rready throttles the master.
module hawk_rd_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]  req_arlen,
  output logic [NUM_REQ-1:0]    req_arready,
  output logic [NUM_REQ-1:0]    req_rvalid,
  input  logic [NUM_REQ-1:0]    req_rready,
  output logic [DATA_W-1:0]     req_rdata,
  output logic [1:0]            req_rresp,
  output logic                  req_rlast,
  output logic                  m_arvalid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [7:0]            m_arlen,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  m_rready,
  output logic [IDW-1:0]        gnt_id,
  output logic                  busy,
  input  logic                  err_clr,
  output logic                  resp_err,
  output logic                  len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, gnt_q, pick;
  logic            found;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]      len_q;
  logic [8:0]      cnt_q;
  logic            resp_err_q, len_err_q;
  logic            beat, resp_set, len_set;
  logic [IDW:0]    sum;

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (!found && req_arvalid[sum[IDW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IDW-1:0];
      end
    end
  end

  assign beat     = (state_q == DATA) && m_rvalid && m_rready;
  assign resp_set = beat && (m_rresp != 2'd0);
  assign len_set  = beat && (m_rlast ? (cnt_q != {1'b0, len_q}) : (cnt_q == {1'b0, len_q}));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = ADDR;
      ADDR:    if (m_arready) state_d = DATA;
      DATA:    if (beat && m_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_arready = '0;
    req_rvalid  = '0;
    m_rready    = 1'b0;
    if (state_q == ADDR) req_arready[gnt_q] = m_arready;
    if (state_q == DATA) begin
      req_rvalid[gnt_q] = m_rvalid;
      m_rready          = req_rready[gnt_q];
    end
  end

  assign m_arvalid = (state_q == ADDR);
  assign m_addr    = addr_q;
  assign m_arlen   = len_q;
  assign gnt_id    = gnt_q;
  assign busy      = (state_q != IDLE);
  assign resp_err  = resp_err_q;
  assign len_err   = len_err_q;
  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(NUM_REQ-1);
      gnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        gnt_q  <= pick;
        addr_q <= req_addr[pick*ADDR_W +: ADDR_W];
        len_q  <= req_arlen[pick*8 +: 8];
      end
      if (state_q == ADDR && m_arready) cnt_q <= '0;
      if (beat) begin
        cnt_q <= cnt_q + 9'd1;
        if (m_rlast) ptr_q <= gnt_q;
      end
      // A new error in the same cycle as err_clr must stay visible.
      if (resp_set)     resp_err_q <= 1'b1;
      else if (err_clr) resp_err_q <= 1'b0;
      if (len_set)      len_err_q  <= 1'b1;
      else if (err_clr) len_err_q  <= 1'b0;
    end
  end

endmodule
